// File: rtl/seq_logic_unit.sv
// Slice-serial AND/OR/XOR/NOR unit: latches operands on start, writes SLICE result bits per clock.
// Latency WIDTH/SLICE cycles from accepted start to done; start is ignored while busy (no queuing).
module seq_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("seq_logic_unit: WIDTH must be a multiple of SLICE");
    end

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;

    function automatic logic [SLICE-1:0] slice_fn(input logic [1:0]       f,
                                                  input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] z);
        logic [SLICE-1:0] r;
        case (f)
            2'b00:   r = x & z;
            2'b01:   r = x | z;
            2'b10:   r = x ^ z;
            default: r = ~(x | z);
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    y_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    zero_d  = 1'b0;
                end
            end
            S_RUN: begin
                // Constant-index slice select keeps the write mux shallow and lint-clean.
                for (int i = 0; i < NSLICE; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        y_d[i*SLICE +: SLICE] = slice_fn(op_q, a_q[i*SLICE +: SLICE],
                                                         b_q[i*SLICE +: SLICE]);
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    zero_d  = (y_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;
    assign zero = zero_q;
endmodule
